// File: rtl/tt_um_test_pattern_if.sv
// Pad-side bundle of the test-pattern tile: enable, user inputs, bidir pads and outputs.
interface tt_um_test_pattern_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_test_pattern.sv
// Pad test-pattern generator: walk/count/LFSR/toggle on uio, loopback on uo.
// Optional pad readback checker enabled by defining PATTERN_CHECK_EN.
module tt_um_test_pattern #(
    parameter int LANES = 8,
    parameter int DIV_W = 16
) (
    input  wire        VGND,
    input  wire        VDPWR,
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    inout  wire  [7:0] ua
);
    localparam logic [2:0] MODE_WALK   = 3'd1;
    localparam logic [2:0] MODE_COUNT  = 3'd2;
    localparam logic [2:0] MODE_LFSR   = 3'd3;
    localparam logic [2:0] MODE_TOGGLE = 3'd4;
    localparam logic [2:0] MODE_LOOP   = 3'd5;
    localparam logic [7:0] LANE_MASK   = 8'((16'd1 << LANES) - 16'd1);

    logic [2:0]       mode_q, mode_prev_q;
    logic [DIV_W-1:0] presc_q, presc_d, presc_max_s;
    logic [7:0]       step_q, step_d, pattern_q, pattern_d, lfsr_q, lfsr_d, lfsr_next_s, rot_s;
    logic [7:0]       uo_q, uo_d, uio_out_q, uio_out_d, uio_oe_q, uio_oe_d;
    logic             run_s, chg_s, tick_s, gen_s, lfsr_fb_s, flag_q, flag_d;

    wire unused_pins_s = &{VGND, VDPWR, ua};

    // Step enable, mode-change detection and next pattern candidates.
    always_comb begin
        run_s       = ui_in[3] & ena;
        presc_max_s = (DIV_W'(1) << ui_in[7:4]) - DIV_W'(1);
        chg_s       = (mode_q != mode_prev_q);
        tick_s      = run_s && (presc_q == presc_max_s);
        gen_s       = (mode_q >= MODE_WALK) && (mode_q <= MODE_TOGGLE);
        lfsr_fb_s   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        lfsr_next_s = {lfsr_q[6:0], lfsr_fb_s};
        rot_s       = ((pattern_q << 1) | (pattern_q >> (LANES - 1))) & LANE_MASK;
    end

    // Prescaler, step counter, pattern and LFSR next state.
    always_comb begin
        presc_d   = presc_q;
        step_d    = step_q;
        pattern_d = pattern_q;
        lfsr_d    = lfsr_q;
        if (chg_s) begin
            presc_d = '0;
            step_d  = 8'd0;
            lfsr_d  = 8'hFF;
            case (mode_q)
                MODE_WALK: pattern_d = 8'h01;
                MODE_LFSR: pattern_d = 8'hFF & LANE_MASK;
                default:   pattern_d = 8'h00;
            endcase
        end else if (tick_s) begin
            presc_d = '0;
            if (gen_s) begin
                step_d = step_q + 8'd1;
            end else begin
                step_d = step_q;
            end
            case (mode_q)
                MODE_WALK:   pattern_d = rot_s;
                MODE_COUNT:  pattern_d = (pattern_q + 8'd1) & LANE_MASK;
                MODE_LFSR: begin
                    lfsr_d    = lfsr_next_s;
                    pattern_d = lfsr_next_s & LANE_MASK;
                end
                MODE_TOGGLE: pattern_d = ~pattern_q & LANE_MASK;
                default:     pattern_d = pattern_q;
            endcase
        end else if (run_s) begin
            presc_d = presc_q + DIV_W'(1);
        end else begin
            presc_d = presc_q;
        end
    end

`ifdef PATTERN_CHECK_EN
    // Sticky flag: pads must read back what was driven on the previous cycle.
    always_comb begin
        if (chg_s) begin
            flag_d = 1'b0;
        end else if (gen_s && ((uio_in & LANE_MASK) != (uio_out_q & LANE_MASK))) begin
            flag_d = 1'b1;
        end else begin
            flag_d = flag_q;
        end
    end
`else
    // Checker absent: flag tied off.
    always_comb begin
        flag_d = 1'b0;
    end
`endif

    // Outputs are decoded from next state so uio follows the tick by one cycle.
    always_comb begin
        if (gen_s) begin
`ifdef PATTERN_CHECK_EN
            uo_d = {flag_d, step_d[6:0]};
`else
            uo_d = step_d;
`endif
            uio_out_d = pattern_d & LANE_MASK;
            uio_oe_d  = LANE_MASK;
        end else if (mode_q == MODE_LOOP) begin
            uo_d      = uio_in;
            uio_out_d = 8'h00;
            uio_oe_d  = 8'h00;
        end else begin
            uo_d      = 8'h00;
            uio_out_d = 8'h00;
            uio_oe_d  = 8'h00;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q      <= 3'd0;
            mode_prev_q <= 3'd0;
            presc_q     <= '0;
            step_q      <= 8'd0;
            pattern_q   <= 8'd0;
            lfsr_q      <= 8'hFF;
            flag_q      <= 1'b0;
            uo_q        <= 8'd0;
            uio_out_q   <= 8'd0;
            uio_oe_q    <= 8'd0;
        end else begin
            mode_q      <= ui_in[2:0];
            mode_prev_q <= mode_q;
            presc_q     <= presc_d;
            step_q      <= step_d;
            pattern_q   <= pattern_d;
            lfsr_q      <= lfsr_d;
            flag_q      <= flag_d;
            uo_q        <= uo_d;
            uio_out_q   <= uio_out_d;
            uio_oe_q    <= uio_oe_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = uio_out_q;
    assign uio_oe  = uio_oe_q;
endmodule

// File: tb/tb_tt_um_test_pattern.sv
// Directed bench for tt_um_test_pattern: LANES=8 and LANES=4 instances share stimulus.
module tb_tt_um_test_pattern;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena_r;
    logic [7:0] ui_r;
    logic [7:0] uio_drv_r;
    logic       loop_sel_r;
    logic       vgnd_r = 1'b0;
    logic       vdpwr_r = 1'b1;
    wire  [7:0] ua8_w = 8'h00;
    wire  [7:0] ua4_w = 8'h00;
    int         tests_run = 0;
    int         tests_failed = 0;
    logic [7:0] lfsr_tab [6] = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1, 8'hC2};

    tt_um_test_pattern_if bus8 ();
    tt_um_test_pattern_if bus4 ();

    assign bus8.ena    = ena_r;
    assign bus4.ena    = ena_r;
    assign bus8.ui_in  = ui_r;
    assign bus4.ui_in  = ui_r;
    assign bus8.uio_in = loop_sel_r ? bus8.uio_out : uio_drv_r;
    assign bus4.uio_in = loop_sel_r ? bus4.uio_out : uio_drv_r;

    always #5 clk = ~clk;

    tt_um_test_pattern #(.LANES(8), .DIV_W(16)) dut8 (
        .VGND(vgnd_r), .VDPWR(vdpwr_r), .clk(clk), .rst_n(rst_n), .ena(bus8.ena),
        .ui_in(bus8.ui_in), .uo_out(bus8.uo_out), .uio_in(bus8.uio_in),
        .uio_out(bus8.uio_out), .uio_oe(bus8.uio_oe), .ua(ua8_w)
    );

    tt_um_test_pattern #(.LANES(4), .DIV_W(16)) dut4 (
        .VGND(vgnd_r), .VDPWR(vdpwr_r), .clk(clk), .rst_n(rst_n), .ena(bus4.ena),
        .ui_in(bus4.ui_in), .uo_out(bus4.uo_out), .uio_in(bus4.uio_in),
        .uio_out(bus4.uio_out), .uio_oe(bus4.uio_oe), .ua(ua4_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // With the checker built in, uo_out[7] is the (clear) flag instead of step[7].
    function automatic logic [7:0] exp_uo(input logic [7:0] s);
`ifdef PATTERN_CHECK_EN
        return {1'b0, s[6:0]};
`else
        return s;
`endif
    endfunction

    task automatic expect8(input string tag, input logic [7:0] uo, input logic [7:0] uio, input logic [7:0] oe);
        check({tag, ".uo8"}, bus8.uo_out, uo);
        check({tag, ".uio8"}, bus8.uio_out, uio);
        check({tag, ".oe8"}, bus8.uio_oe, oe);
    endtask

    initial begin
        rst_n = 1'b0; ena_r = 1'b1; ui_r = 8'h00; uio_drv_r = 8'h00; loop_sel_r = 1'b1;
        step(2);
        expect8("reset", 8'h00, 8'h00, 8'h00);
        check("reset.uio4", bus4.uio_out, 8'h00);

        // WALK, s=0: mode registers, then change loads the seed
        rst_n = 1'b1; ui_r = 8'h09;
        step(2);
        expect8("walk.seed", 8'h00, 8'h01, 8'hFF);
        check("walk.oe4", bus4.uio_oe, 8'h0F);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            expect8($sformatf("walk%0d", k), 8'(k), 8'(32'd1 << (k % 8)), 8'hFF);
            check($sformatf("walk4_%0d", k), bus4.uio_out, 8'(32'd1 << (k % 4)));
        end

        // COUNT, s=2: one increment every four cycles
        ui_r = 8'h2A;
        step(2);
        expect8("count.seed", 8'h00, 8'h00, 8'hFF);
        for (int t = 1; t <= 17; t++) begin
            step(3);
            if (t == 1) check("count.hold3", bus4.uio_out, 8'h00);
            step(1);
            check($sformatf("count4_%0d", t), bus4.uio_out, 8'(t % 16));
            check($sformatf("count4oe_%0d", t), bus4.uio_oe, 8'h0F);
        end
        expect8("count17", 8'd17, 8'd17, 8'hFF);

        // run=0 and ena=0 both freeze
        ui_r = 8'h22;
        step(10);
        expect8("runoff", 8'd17, 8'd17, 8'hFF);
        ui_r = 8'h2A;
        step(4);
        expect8("resume", 8'd18, 8'd18, 8'hFF);
        ena_r = 1'b0;
        step(6);
        expect8("enaoff", 8'd18, 8'd18, 8'hFF);
        ena_r = 1'b1;

        // reset mid-run clears all outputs
        rst_n = 1'b0;
        step(1);
        expect8("midreset", 8'h00, 8'h00, 8'h00);
        check("midreset.oe4", bus4.uio_oe, 8'h00);

        // LFSR, s=0
        rst_n = 1'b1; ui_r = 8'h0B;
        step(2);
        expect8("lfsr.seed", 8'h00, 8'hFF, 8'hFF);
        check("lfsr4.seed", bus4.uio_out, 8'h0F);
        for (int i = 0; i < 6; i++) begin
            step(1);
            expect8($sformatf("lfsr%0d", i + 1), 8'(i + 1), lfsr_tab[i], 8'hFF);
        end
        check("lfsr4.6", bus4.uio_out, 8'h02);
        step(249);
        expect8("lfsr.period", exp_uo(8'd255), 8'hFF, 8'hFF);
        step(1);
        expect8("lfsr.wrap", 8'h00, 8'hFE, 8'hFF);

        // TOGGLE reloads 0x00
        ui_r = 8'h0C;
        step(2);
        expect8("toggle.seed", 8'h00, 8'h00, 8'hFF);
        step(1);
        expect8("toggle1", 8'h01, 8'hFF, 8'hFF);
        check("toggle4", bus4.uio_out, 8'h0F);
        step(1);
        expect8("toggle2", 8'h02, 8'h00, 8'hFF);

        // IDLE and mode 7
        ui_r = 8'h08;
        step(2);
        expect8("idle", 8'h00, 8'h00, 8'h00);
        ui_r = 8'h0F;
        step(2);
        expect8("mode7", 8'h00, 8'h00, 8'h00);

        // LOOP: registered uio_in, run is irrelevant
        ui_r = 8'h05; loop_sel_r = 1'b0; uio_drv_r = 8'h3C;
        step(2);
        expect8("loop.3c", 8'h3C, 8'h00, 8'h00);
        uio_drv_r = 8'hA5;
        #1;
        check("loop.latency", bus8.uo_out, 8'h3C);
        step(1);
        expect8("loop.a5", 8'hA5, 8'h00, 8'h00);
        check("loop4.a5", bus4.uo_out, 8'hA5);
        ui_r = 8'h0D; uio_drv_r = 8'h66;
        step(1);
        check("loop.run", bus8.uo_out, 8'h66);

`ifdef PATTERN_CHECK_EN
        // stuck-low pads in WALK set the sticky flag; mode change clears it
        ui_r = 8'h09; uio_drv_r = 8'h00;
        step(3);
        check("chk.set", bus8.uo_out[7], 1'b1);
        step(5);
        check("chk.sticky", bus8.uo_out[7], 1'b1);
        ui_r = 8'h0A;
        step(2);
        check("chk.clear", bus8.uo_out[7], 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
